udp_cmd_ctrl: RTL

Host-command controller for the UDP receive path. It captures the payload bytes streamed by the GMII UDP receiver and commits a command only after the receiver marks the packet good (done pulse with no error). It then decodes the command, updates an 8-entry × 32-bit configuration register file and fires acquisition start/stop pulses. It also raises an acknowledge request toward the UDP transmit side. It runs in the receiver's clock domain, between the UDP RX block and the acquisition/TX logic.

---
 rtl/udp_cmd_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/udp_cmd_ctrl.sv
// Host-command controller: buffers UDP payload bytes, validates the packet on a good done pulse,
// executes register writes/reads and acquisition start/stop. Ack handshake is built when UDP_CMD_ACK_EN is defined.
module udp_cmd_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         payload_valid,
    input  logic [7:0]   payload_dat,
    input  logic [15:0]  rx_data_length,
    input  logic         one_pkt_done,
    input  logic         pkt_error,
    input  logic         ack_ready,
    output logic [255:0] reg_flat,
    output logic         start_pulse,
    output logic         stop_pulse,
    output logic         busy,
    output logic         ack_valid,
    output logic [7:0]   ack_op,
    output logic [7:0]   ack_addr,
    output logic [31:0]  ack_data,
    output logic [1:0]   ack_status,
    output logic [15:0]  cmd_cnt,
    output logic [15:0]  err_cnt
);
    localparam logic [15:0] CMD_MAGIC = 16'hA55A;
    localparam logic [3:0]  CMD_LEN   = 4'd8;
    localparam logic [15:0] CMD_LEN_W = 16'd8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             first_q;
    logic [3:0]       byte_cnt_q;
    logic [7:0][7:0]  shadow_q;
    logic [7:0][7:0]  cmd_q;
    logic             pkt_err_q;
    logic [3:0]       cnt_q;
    logic [15:0]      len_q;
    logic [7:0][31:0] regs_q;
    logic             start_q, stop_q;
    logic [15:0]      cmd_cnt_q, cmd_cnt_d, err_cnt_q, err_cnt_d;

    logic [7:0]  op, addr;
    logic [31:0] wdata;
    logic        addr_ok, accept, exec, check_fail, drop, new_pkt, ack_done;

    // A byte arriving together with one_pkt_done already belongs to the next packet.
    assign new_pkt = first_q | one_pkt_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q    <= 1'b1;
            byte_cnt_q <= '0;
            shadow_q   <= '0;
        end else begin
            if (payload_valid) begin
                first_q <= 1'b0;
                if (new_pkt) begin
                    byte_cnt_q  <= 4'd1;
                    shadow_q[0] <= payload_dat;
                end else begin
                    if (!byte_cnt_q[3]) shadow_q[byte_cnt_q[2:0]] <= payload_dat;
                    if (byte_cnt_q != 4'hF) byte_cnt_q <= byte_cnt_q + 4'd1;
                end
            end else if (one_pkt_done) begin
                first_q <= 1'b1;
            end
        end
    end

    assign op         = cmd_q[2];
    assign addr       = cmd_q[3];
    assign wdata      = {cmd_q[4], cmd_q[5], cmd_q[6], cmd_q[7]};
    assign addr_ok    = (addr[7:3] == 5'd0);
    assign accept     = !pkt_err_q && (cnt_q == CMD_LEN) && (len_q == CMD_LEN_W) &&
                        ({cmd_q[0], cmd_q[1]} == CMD_MAGIC);
    assign exec       = (state_q == S_EXEC);
    assign check_fail = (state_q == S_CHECK) && !accept;
    assign drop       = one_pkt_done && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (one_pkt_done) state_d = S_CHECK;
            S_CHECK: state_d = accept ? S_EXEC : S_IDLE;
`ifdef UDP_CMD_ACK_EN
            S_EXEC:  state_d = S_ACK;
`else
            S_EXEC:  state_d = S_IDLE;
`endif
            S_ACK:   if (ack_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_cnt_d = cmd_cnt_q + {15'd0, exec};
    assign err_cnt_d = err_cnt_q + {15'd0, check_fail} + {15'd0, drop};

    // Packet snapshot is taken on the accepted done pulse so later bytes cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            pkt_err_q <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            regs_q    <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_cnt_q <= cmd_cnt_d;
            err_cnt_q <= err_cnt_d;
            start_q   <= exec && (op == 8'h03);
            stop_q    <= exec && (op == 8'h04);
            if ((state_q == S_IDLE) && one_pkt_done) begin
                pkt_err_q <= pkt_error;
                cnt_q     <= byte_cnt_q;
                len_q     <= rx_data_length;
                cmd_q     <= shadow_q;
            end
            if (exec && (op == 8'h01) && addr_ok) regs_q[addr[2:0]] <= wdata;
        end
    end

    assign reg_flat    = regs_q;
    assign start_pulse = start_q;
    assign stop_pulse  = stop_q;
    assign busy        = (state_q != S_IDLE);
    assign cmd_cnt     = cmd_cnt_q;
    assign err_cnt     = err_cnt_q;

`ifdef UDP_CMD_ACK_EN
    logic [7:0]  ack_op_q, ack_addr_q;
    logic [31:0] ack_data_q;
    logic [1:0]  ack_status_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_op_q     <= '0;
            ack_addr_q   <= '0;
            ack_data_q   <= '0;
            ack_status_q <= '0;
        end else if (exec) begin
            ack_op_q     <= op;
            ack_addr_q   <= addr;
            ack_data_q   <= wdata;
            ack_status_q <= 2'd0;
            case (op)
                8'h01: if (!addr_ok) ack_status_q <= 2'd2;
                8'h02: begin
                    if (addr_ok) ack_data_q <= regs_q[addr[2:0]];
                    else         ack_status_q <= 2'd2;
                end
                8'h03, 8'h04: ;
                default: ack_status_q <= 2'd1;
            endcase
        end
    end

    assign ack_valid  = (state_q == S_ACK);
    assign ack_op     = ack_op_q;
    assign ack_addr   = ack_addr_q;
    assign ack_data   = ack_data_q;
    assign ack_status = ack_status_q;
    assign ack_done   = ack_valid & ack_ready;
`else
    logic unused_ack_ready;
    assign unused_ack_ready = ack_ready;
    assign ack_valid  = 1'b0;
    assign ack_op     = '0;
    assign ack_addr   = '0;
    assign ack_data   = '0;
    assign ack_status = '0;
    assign ack_done   = 1'b0;
`endif

endmodule
